// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: LC-3b memory word/mask types and the arbiter state encoding
// shared by the instruction/data memory arbiter.
package mem_arbiter_pkg;
    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;
    typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D} arb_state_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between instruction and data sides.
// Define ARB_RR_EN for round-robin tie breaking; otherwise the data side always wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_read,
    input  lc3b_word      i_address,
    output lc3b_word      i_rdata,
    output logic          i_resp,
    input  logic          d_read,
    input  logic          d_write,
    input  lc3b_word      d_address,
    input  lc3b_word      d_wdata,
    input  lc3b_mem_wmask d_byte_enable,
    output lc3b_word      d_rdata,
    output logic          d_resp,
    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_word      pmem_address,
    output lc3b_word      pmem_wdata,
    output lc3b_mem_wmask pmem_byte_enable,
    input  lc3b_word      pmem_rdata,
    input  logic          pmem_resp
);
    arb_state_t    state, state_next;
    lc3b_word      addr_q, wdata_q;
    lc3b_mem_wmask be_q;
    logic          write_q, grant_d, take;
`ifdef ARB_RR_EN
    logic          last_d;
    // on a tie the side that was not served last goes first
    assign grant_d = (d_read | d_write) & (~i_read | ~last_d);
`else
    assign grant_d = d_read | d_write;
`endif
    assign take = (state == IDLE) && (state_next != IDLE);
    assign pmem_address = addr_q;
    assign pmem_wdata = wdata_q;
    assign pmem_byte_enable = be_q;
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = grant_d ? GRANT_D : (i_read ? GRANT_I : IDLE);
            GRANT_I: state_next = pmem_resp ? RESP_I : GRANT_I;
            GRANT_D: state_next = pmem_resp ? RESP_D : GRANT_D;
            default: state_next = IDLE;
        endcase
    end
    always_comb begin
        pmem_read = (state == GRANT_I || state == GRANT_D) && !write_q;
        pmem_write = (state == GRANT_I || state == GRANT_D) && write_q;
        i_resp = state == RESP_I;
        d_resp = state == RESP_D;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            be_q <= '0;
            write_q <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
`ifdef ARB_RR_EN
            last_d <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (take) begin
                addr_q <= grant_d ? d_address : i_address;
                wdata_q <= grant_d ? d_wdata : '0;
                write_q <= grant_d & d_write;
                be_q <= (grant_d & d_write) ? d_byte_enable : 2'b11;
`ifdef ARB_RR_EN
                last_d <= grant_d;
`endif
            end
            if (state == GRANT_I && pmem_resp) i_rdata <= pmem_rdata;
            if (state == GRANT_D && pmem_resp && !write_q) d_rdata <= pmem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a word-array
// memory reference and a served-side ordering model (follows ARB_RR_EN like the DUT).
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [15:0] i_address = '0, d_address = '0, d_wdata = '0;
    logic [1:0]  d_byte_enable = '0;
    logic [15:0] i_rdata, d_rdata, pmem_address, pmem_wdata, pmem_rdata;
    logic        i_resp, d_resp, pmem_read, pmem_write, pmem_resp;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] smem [256];
    logic [15:0] ref_mem [256];
    logic [15:0] exp_i_rdata = '0, exp_d_rdata = '0;
    bit          last_served_d = 1'b0;
    int          lat = 1, cnt = 0;
    int          total = 0, bad = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    // physical memory: responds in the lat-th cycle of a held strobe
    assign pmem_resp = (pmem_read || pmem_write) && (cnt == lat - 1);
    assign pmem_rdata = smem[pmem_address[8:1]];
    always @(posedge clk) begin
        cnt <= ((pmem_read || pmem_write) && !pmem_resp) ? cnt + 1 : 0;
        if (pmem_resp && pmem_write) begin
            if (pmem_byte_enable[0]) smem[pmem_address[8:1]][7:0] <= pmem_wdata[7:0];
            if (pmem_byte_enable[1]) smem[pmem_address[8:1]][15:8] <= pmem_wdata[15:8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit tie_winner_d();
`ifdef ARB_RR_EN
        return !last_served_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic do_single(input bit side_d, input bit wr, input bit rd_too,
                             input logic [15:0] addr, input logic [15:0] wd,
                             input logic [1:0] be, input int lat_c);
        int n_strobe = 0;
        bit done = 0;
        logic [15:0] exp_rd = ref_mem[addr[8:1]];
        logic [15:0] merged = ref_mem[addr[8:1]];
        logic [1:0] exp_be = (side_d && wr) ? be : 2'b11;
        lat = lat_c;
        if (side_d) begin
            d_address = addr; d_wdata = wd; d_byte_enable = be;
            d_write = wr; d_read = !wr || rd_too;
        end else begin
            i_address = addr; i_read = 1'b1;
        end
        for (int n = 1; n <= 30 && !done; n++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) begin
                n_strobe++;
                chk("strobe_dir", {pmem_read, pmem_write}, (side_d && wr) ? 2'b01 : 2'b10);
                chk("pmem_addr", pmem_address, addr);
                chk("pmem_be", pmem_byte_enable, exp_be);
                if (side_d && wr) chk("pmem_wdata", pmem_wdata, wd);
                // in-flight access must ignore later requester changes
                if (side_d) begin
                    d_address = 16'($urandom); d_wdata = 16'($urandom); d_byte_enable = 2'($urandom);
                end else i_address = 16'($urandom);
            end
            if (i_resp || d_resp) begin
                done = 1;
                chk("resp_side", {i_resp, d_resp}, side_d ? 2'b01 : 2'b10);
                chk("resp_latency", n, lat_c + 1);
                chk("strobe_cycles", n_strobe, lat_c);
                chk("resp_strobes_off", {pmem_read, pmem_write}, 2'b00);
                if (side_d && wr) begin
                    if (be[0]) merged[7:0] = wd[7:0];
                    if (be[1]) merged[15:8] = wd[15:8];
                    ref_mem[addr[8:1]] = merged;
                end else if (side_d) exp_d_rdata = exp_rd;
                else exp_i_rdata = exp_rd;
                chk("i_rdata", i_rdata, exp_i_rdata);
                chk("d_rdata", d_rdata, exp_d_rdata);
                i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
                last_served_d = side_d;
            end
        end
        chk("single_done", done, 1'b1);
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
        chk("resp_pulse", {i_resp, d_resp}, 2'b00);
        chk("idle_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("i_rdata_hold", i_rdata, exp_i_rdata);
        chk("d_rdata_hold", d_rdata, exp_d_rdata);
    endtask

    // both sides read; with refill each side re-requests right after its resp
    task automatic do_race(input int n_acc, input bit refill);
        int served = 0;
        bit pend_i = 1, pend_d = 1, exp_d;
        logic [15:0] ai = 16'($urandom_range(0, 511)), ad = 16'($urandom_range(0, 511));
        lat = $urandom_range(1, 3);
        i_address = ai; d_address = ad; i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
        exp_d = tie_winner_d();
        for (int n = 0; n < 400 && served < n_acc; n++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) chk("race_addr", pmem_address, exp_d ? ad : ai);
            if (i_resp || d_resp) begin
                chk("race_order", {i_resp, d_resp}, exp_d ? 2'b01 : 2'b10);
                if (exp_d) begin
                    exp_d_rdata = ref_mem[ad[8:1]];
                    chk("race_d_rdata", d_rdata, exp_d_rdata);
                end else begin
                    exp_i_rdata = ref_mem[ai[8:1]];
                    chk("race_i_rdata", i_rdata, exp_i_rdata);
                end
                last_served_d = exp_d;
                served++;
                if (refill && served < n_acc) begin
                    if (exp_d) begin ad = 16'($urandom_range(0, 511)); d_address = ad; end
                    else begin ai = 16'($urandom_range(0, 511)); i_address = ai; end
                end else if (exp_d) begin pend_d = 0; d_read = 1'b0; end
                else begin pend_i = 0; i_read = 1'b0; end
                exp_d = (pend_i && pend_d) ? tie_winner_d() : pend_d;
            end
        end
        chk("race_done", served, n_acc);
        i_read = 1'b0; d_read = 1'b0;
        repeat (2) @(negedge clk);
        chk("race_drain", {i_resp, d_resp, pmem_read, pmem_write}, 4'b0000);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            smem[k] = 16'($urandom);
            ref_mem[k] = smem[k];
        end
        smem[8'h20] = 16'h1234; ref_mem[8'h20] = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        chk("rst_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("rst_i_rdata", i_rdata, 16'h0);
        chk("rst_d_rdata", d_rdata, 16'h0);
        chk("rst_pmem_addr", pmem_address, 16'h0);
        chk("rst_pmem_be", pmem_byte_enable, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        do_single(0, 0, 0, 16'h0040, 16'h0, 2'b00, 3);
        chk("i_rdata_1234", i_rdata, 16'h1234);
        do_single(1, 1, 0, 16'h0101, 16'hAB00, 2'b10, 2);
        do_single(1, 0, 0, 16'h0100, 16'h0, 2'b00, 1);
        do_single(1, 1, 1, 16'h0010, 16'h5A5A, 2'b01, 2);
        do_single(0, 0, 0, 16'h0010, 16'h0, 2'b00, 4);
        do_race(2, 0);
        do_race(8, 1);
        i_address = 16'h0040; i_read = 1'b1; lat = 4;
        repeat (2) @(negedge clk);
        chk("pre_rst_strobe", pmem_read, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_strobe", {pmem_read, pmem_write}, 2'b00);
        chk("rst_mid_resp", i_resp, 1'b0);
        i_read = 1'b0;
        exp_i_rdata = '0; exp_d_rdata = '0; last_served_d = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_hold_resp", {i_resp, d_resp}, 2'b00);
            chk("rst_hold_rdata", i_rdata, 16'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        do_single(0, 0, 0, 16'h0040, 16'h0, 2'b00, 2);
        do_race(2, 0);
        for (int k = 0; k < 24; k++) begin
            bit sd = 1'($urandom);
            bit w = sd && 1'($urandom);
            do_single(sd, w, 1'($urandom), 16'($urandom_range(0, 511)), 16'($urandom),
                      2'($urandom), $urandom_range(1, 4));
        end
        for (int k = 0; k < 4; k++) begin
            logic [15:0] a = 16'($urandom_range(0, 511));
            do_single(0, 0, 0, a, 16'h0, 2'b00, $urandom_range(1, 3));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
